// File: rtl/cpu_memory.sv
// Word-addressed 16-bit instruction/data memory with a byte-serial program loader that holds the CPU in reset.
// Latency: reads registered, 1 cycle, read-first; writes land on the clock edge; cpu_reset follows state by one edge.
// Backpressure: load_ready is high in every load state and each valid byte is taken that cycle; RUN accepts no bytes.
module cpu_memory #(
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [15:0]          pc,
    output logic [15:0]          instruction,
    input  logic [15:0]          addr,
    input  logic                 write,
    input  logic [15:0]          cpu_out,
    output logic [15:0]          data,
    output logic                 cpu_reset,
    input  logic                 load_start,
    input  logic                 load_valid,
    input  logic [7:0]           load_byte,
    output logic                 load_ready,
    input  logic                 load_end,
    output logic [ADDR_BITS-1:0] load_ptr
);
    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] PTR_ONE = 1;

    typedef enum logic [1:0] {RUN, LOAD_LO, LOAD_HI} state_t;

    state_t               state;
    logic [7:0]           lo_byte;
    logic [ADDR_BITS-1:0] ptr;
    logic [15:0]          mem [DEPTH];

    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_wa;
    logic [15:0]          mem_wd;

    // Upper address bits are intentionally ignored.
    logic unused_hi;
    assign unused_hi = ^{pc[15:ADDR_BITS], addr[15:ADDR_BITS]};

    assign load_ready = (state != RUN);
    assign load_ptr   = ptr;

    // Single write port shared by the CPU (RUN) and the loader (LOAD_*).
    always_comb begin
        mem_we = 1'b0;
        mem_wa = addr[ADDR_BITS-1:0];
        mem_wd = cpu_out;
        if (!reset) begin
            case (state)
                RUN: mem_we = write;
                LOAD_LO: begin
                    if (load_valid && load_end) begin
                        mem_we = 1'b1;
                        mem_wa = ptr;
                        mem_wd = {8'h00, load_byte};
                    end
                end
                LOAD_HI: begin
                    if (load_valid) begin
                        mem_we = 1'b1;
                        mem_wa = ptr;
                        mem_wd = {load_byte, lo_byte};
                    end else if (load_end) begin
                        mem_we = 1'b1;
                        mem_wa = ptr;
                        mem_wd = {8'h00, lo_byte};
                    end
                end
                default: mem_we = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            ptr         <= '0;
            lo_byte     <= '0;
            cpu_reset   <= 1'b1;
            instruction <= '0;
            data        <= '0;
        end else begin
            cpu_reset <= (state != RUN);
            if (state == RUN) begin
                instruction <= mem[pc[ADDR_BITS-1:0]];
                data        <= mem[addr[ADDR_BITS-1:0]];
            end else begin
                instruction <= '0;
                data        <= '0;
            end

            // Every loader write advances the pointer; it wraps naturally.
            if (mem_we && state != RUN) begin
                ptr <= ptr + PTR_ONE;
            end

            case (state)
                RUN: begin
                    if (load_start) begin
                        state <= LOAD_LO;
                        ptr   <= '0;
                    end
                end
                LOAD_LO: begin
                    if (load_valid && !load_end) begin
                        lo_byte <= load_byte;
                        state   <= LOAD_HI;
                    end else if (load_end) begin
                        state <= RUN;
                    end
                end
                LOAD_HI: begin
                    if (load_valid) begin
                        state <= load_end ? RUN : LOAD_LO;
                    end else if (load_end) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_memory.sv
// Directed bench for cpu_memory; read results are checked against a queue of expected words.
module tb_cpu_memory;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc, addr, cpu_out;
    logic        write;
    logic [15:0] instruction, data;
    logic        cpu_reset;
    logic        load_start, load_valid, load_end, load_ready;
    logic [7:0]  load_byte;
    logic [7:0]  load_ptr;

    int checks = 0;
    int errors = 0;
    logic [15:0] iq[$];
    logic [15:0] dq[$];

    cpu_memory #(.ADDR_BITS(8)) dut (
        .clk(clk), .reset(reset),
        .pc(pc), .instruction(instruction),
        .addr(addr), .write(write), .cpu_out(cpu_out), .data(data),
        .cpu_reset(cpu_reset),
        .load_start(load_start), .load_valid(load_valid), .load_byte(load_byte),
        .load_ready(load_ready), .load_end(load_end), .load_ptr(load_ptr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag);
        logic [15:0] e;
        if (iq.size() == 0 || dq.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            e = iq.pop_front();
            chk({tag, "_inst"}, instruction, e);
            e = dq.pop_front();
            chk({tag, "_data"}, data, e);
        end
    endtask

    // Read both ports; optionally store on the data port in the same cycle.
    task automatic rd(input string tag, input logic [15:0] p, input logic [15:0] a,
                      input logic w, input logic [15:0] wv,
                      input logic [15:0] ei, input logic [15:0] ed);
        pc = p; addr = a; write = w; cpu_out = wv;
        iq.push_back(ei);
        dq.push_back(ed);
        step();
        write = 1'b0;
        pop_chk(tag);
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] v);
        addr = a; cpu_out = v; write = 1'b1;
        step();
        write = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input logic e);
        load_valid = 1'b1; load_byte = b; load_end = e;
        step();
        load_valid = 1'b0; load_end = 1'b0;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    task automatic end_load();
        load_end = 1'b1;
        step();
        load_end = 1'b0;
    endtask

    initial begin
        logic [15:0] w;
        reset = 1'b1; pc = '0; addr = '0; cpu_out = '0; write = 1'b0;
        load_start = 1'b0; load_valid = 1'b0; load_end = 1'b0; load_byte = '0;

        // Reset state
        step(); step();
        chk("rst_inst", instruction, 16'h0000);
        chk("rst_data", data, 16'h0000);
        chk("rst_cpu_reset", {15'd0, cpu_reset}, 16'h0001);
        chk("rst_ready", {15'd0, load_ready}, 16'h0000);
        chk("rst_ptr", {8'd0, load_ptr}, 16'h0000);
        reset = 1'b0;
        step();
        chk("rel_cpu_reset", {15'd0, cpu_reset}, 16'h0000);

        // Even-length load
        start_load();
        chk("ld1_ready", {15'd0, load_ready}, 16'h0001);
        send(8'h00, 1'b0);
        chk("ld1_cpu_reset", {15'd0, cpu_reset}, 16'h0001);
        send(8'h40, 1'b0);
        send(8'hFF, 1'b0);
        send(8'h6F, 1'b0);
        chk("ld1_ptr_mid", {8'd0, load_ptr}, 16'h0002);
        end_load();
        chk("ld1_ptr", {8'd0, load_ptr}, 16'h0002);
        chk("ld1_ready_off", {15'd0, load_ready}, 16'h0000);
        chk("ld1_cpu_reset_hold", {15'd0, cpu_reset}, 16'h0001);
        step();
        chk("ld1_cpu_reset_rel", {15'd0, cpu_reset}, 16'h0000);
        rd("ld1_rd", 16'd1, 16'd0, 1'b0, 16'h0, 16'h6FFF, 16'h4000);

        // Read-first on both ports during a store
        wr(16'd5, 16'h1111);
        rd("rf_same", 16'd5, 16'd5, 1'b1, 16'h0050, 16'h1111, 16'h1111);
        rd("rf_next", 16'd5, 16'd5, 1'b0, 16'h0, 16'h0050, 16'h0050);

        // Odd-length load zero-pads; outputs forced to 0 while loading
        start_load();
        send(8'h0B, 1'b0);
        chk("ld2_inst_forced", instruction, 16'h0000);
        chk("ld2_data_forced", data, 16'h0000);
        send(8'hC6, 1'b0);
        send(8'h01, 1'b0);
        end_load();
        chk("ld2_ptr", {8'd0, load_ptr}, 16'h0002);
        step();
        rd("ld2_rd", 16'd0, 16'd1, 1'b0, 16'h0, 16'hC60B, 16'h0001);

        // Store ignored while loading; valid+end in LOAD_HI and LOAD_LO
        wr(16'd7, 16'h7777);
        start_load();
        addr = 16'd7; cpu_out = 16'hFFFF; write = 1'b1;
        step();
        write = 1'b0;
        send(8'h34, 1'b0);
        send(8'h12, 1'b1);
        chk("vend_hi_ptr", {8'd0, load_ptr}, 16'h0001);
        step();
        rd("vend_hi_rd", 16'd0, 16'd7, 1'b0, 16'h0, 16'h1234, 16'h7777);
        start_load();
        send(8'hAA, 1'b1);
        chk("vend_lo_ptr", {8'd0, load_ptr}, 16'h0001);
        step();
        rd("vend_lo_rd", 16'd0, 16'd1, 1'b0, 16'h0, 16'h00AA, 16'h0001);

        // load_start beats load_end in RUN; stray bytes in RUN ignored
        load_start = 1'b1; load_end = 1'b1;
        step();
        load_start = 1'b0; load_end = 1'b0;
        chk("start_wins_ready", {15'd0, load_ready}, 16'h0001);
        end_load();
        step();
        send(8'h99, 1'b0);
        chk("run_byte_ptr", {8'd0, load_ptr}, 16'h0000);
        chk("run_byte_ready", {15'd0, load_ready}, 16'h0000);
        rd("run_byte_rd", 16'd0, 16'd1, 1'b0, 16'h0, 16'h00AA, 16'h0001);

        // Upper address bits ignored
        wr(16'h0105, 16'h1234);
        rd("alias_rd", 16'h0305, 16'h0005, 1'b0, 16'h0, 16'h1234, 16'h1234);

        // Pointer wrap: 257 words overwrite word 0
        start_load();
        for (int k = 0; k < 257; k++) begin
            w = 16'hA000 + 16'(k);
            send(w[7:0], 1'b0);
            send(w[15:8], 1'b0);
        end
        end_load();
        chk("wrap_ptr", {8'd0, load_ptr}, 16'h0001);
        step();
        rd("wrap_rd0", 16'd0, 16'd255, 1'b0, 16'h0, 16'hA100, 16'hA0FF);
        rd("wrap_rd1", 16'd1, 16'd2, 1'b0, 16'h0, 16'hA001, 16'hA002);

        // Reset mid-load: pending low byte dropped, written words kept
        start_load();
        send(8'h66, 1'b0);
        send(8'h55, 1'b0);
        send(8'h77, 1'b0);
        chk("mid_ptr_pre", {8'd0, load_ptr}, 16'h0001);
        reset = 1'b1;
        step();
        chk("mid_ptr", {8'd0, load_ptr}, 16'h0000);
        chk("mid_cpu_reset", {15'd0, cpu_reset}, 16'h0001);
        chk("mid_ready", {15'd0, load_ready}, 16'h0000);
        reset = 1'b0;
        step();
        chk("mid_cpu_reset_rel", {15'd0, cpu_reset}, 16'h0000);
        rd("mid_rd", 16'd0, 16'd1, 1'b0, 16'h0, 16'h5566, 16'hA001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
